// File: rtl/anon_struct_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin struct arbiter.
package anon_struct_pkg;

    localparam int FIELD_W_DEFAULT = 2;

    typedef struct packed {
        logic [FIELD_W_DEFAULT-1:0] hi;
        logic [FIELD_W_DEFAULT-1:0] lo;
    } payload_t;

    // A hi field equal to this value reserves the channel for the sender's next beat.
    localparam logic [FIELD_W_DEFAULT-1:0] LOCK_FIELD = '1;

endpackage

// File: rtl/anon_struct_rr_arbiter_if.sv
// Requester and output-channel bundle for the round-robin arbiter.
interface anon_struct_rr_arbiter_if
    import anon_struct_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int FIELD_W = FIELD_W_DEFAULT
);
    localparam int PW = 2 * FIELD_W;
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*PW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  out_valid;
    logic [PW-1:0]         out_data;
    logic [IW-1:0]         out_src;
    logic                  out_ready;
    logic                  locked;

    // Requesters plus downstream consumer.
    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_src, locked
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_src, locked
    );

endinterface

// File: rtl/anon_struct_rr_arbiter_rr_pick.sv
// Rotating priority pick: first set request at or after ptr, modulo N.
module rr_pick #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);

    int pos;

    // Walk offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = (int'(ptr) + k) % N;
            if (req[pos]) begin
                idx   = IW'(pos);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/anon_struct_rr_arbiter.sv
// Round-robin arbiter feeding one registered payload channel, with
// single-beat lock continuation when a payload's hi field is all-ones.
module anon_struct_rr_arbiter
    import anon_struct_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int FIELD_W = FIELD_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    anon_struct_rr_arbiter_if.slave  bus
);

    localparam int PW = 2 * FIELD_W;
    localparam int IW = $clog2(NUM_REQ);

    logic              out_valid_q, out_valid_d;
    logic [PW-1:0]     out_data_q, out_data_d;
    logic [IW-1:0]     out_src_q, out_src_d;
    logic              locked_q, locked_d;
    logic [IW-1:0]     lock_owner_q, lock_owner_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] owner_mask;
    logic [NUM_REQ-1:0] eligible;
    logic [IW-1:0]      grant_idx;
    logic               grant_found;
    logic               can_accept;
    logic               accept;
    logic [PW-1:0]      sel_payload;
    logic               sel_lock;

    // While locked only the owner may be picked; everyone else is masked.
    always_comb begin
        owner_mask = {{(NUM_REQ-1){1'b0}}, 1'b1} << lock_owner_q;
        eligible   = locked_q ? (bus.req_valid & owner_mask) : bus.req_valid;
    end

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (eligible),
        .ptr   (rr_ptr_q),
        .idx   (grant_idx),
        .found (grant_found)
    );

    // Handshake, payload mux and next-state for the output register.
    always_comb begin
        can_accept  = !out_valid_q || bus.out_ready;
        accept      = grant_found && can_accept && !rst;
        sel_payload = bus.req_data[grant_idx*PW +: PW];
        sel_lock    = &sel_payload[PW-1 -: FIELD_W];

        bus.req_ready = '0;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_src_d     = out_src_q;
        locked_d      = locked_q;
        lock_owner_d  = lock_owner_q;
        rr_ptr_d      = rr_ptr_q;

        if (accept) begin
            bus.req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
            out_valid_d   = 1'b1;
            out_data_d    = sel_payload;
            out_src_d     = grant_idx;
            locked_d      = sel_lock;
            lock_owner_d  = grant_idx;
            rr_ptr_d      = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset drops any held beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= '0;
            locked_q     <= 1'b0;
            lock_owner_q <= '0;
            rr_ptr_q     <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            locked_q     <= locked_d;
            lock_owner_q <= lock_owner_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.locked    = locked_q;

endmodule

// File: tb/tb_anon_struct_rr_arbiter.sv
// Randomized and directed checks of the round-robin arbiter against a
// behavioural reference model.
module tb_anon_struct_rr_arbiter;
    import anon_struct_pkg::*;

    localparam int N = 4;

    logic clk;
    logic rst;

    anon_struct_rr_arbiter_if #(.NUM_REQ(N), .FIELD_W(2)) bus ();

    anon_struct_rr_arbiter #(.NUM_REQ(N), .FIELD_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state.
    int m_ov, m_od, m_os, m_lk, m_own, m_ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ov = 0; m_od = 0; m_os = 0; m_lk = 0; m_own = 0; m_ptr = 0;
    endtask

    // One clock cycle: drive, check against model, clock, advance model.
    task automatic step(input logic [3:0] v, input logic [15:0] d, input logic ordy);
        int g;
        int idx;
        int pl;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_data  = d;
        bus.out_ready = ordy;
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
        chk("out_data",  32'(bus.out_data),  32'(m_od));
        chk("out_src",   32'(bus.out_src),   32'(m_os));
        chk("locked",    32'(bus.locked),    32'(m_lk));
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && v[idx] && (m_lk == 0 || idx == m_own)) g = idx;
        end
        if (m_ov != 0 && !ordy) g = -1;
        chk("req_ready", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        @(posedge clk);
        if (g >= 0) begin
            pl    = int'(d[g*4 +: 4]);
            m_od  = pl;
            m_os  = g;
            m_ov  = 1;
            m_ptr = (g + 1) % N;
            m_lk  = ((pl >> 2) == int'(LOCK_FIELD)) ? 1 : 0;
            m_own = g;
        end else if (m_ov != 0 && ordy) begin
            m_ov = 0;
        end
    endtask

    logic [3:0] pays [4];
    payload_t   lock_pl;

    initial begin
        pays[0] = 4'h1; pays[1] = 4'h2; pays[2] = 4'h3; pays[3] = 4'h5;
        lock_pl = '{hi: LOCK_FIELD, lo: 2'b01};

        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data",  32'(bus.out_data),  0);
        chk("rst_out_src",   32'(bus.out_src),   0);
        chk("rst_locked",    32'(bus.locked),    0);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        rst = 1'b0;

        // Rotation: everyone valid, one beat per cycle, 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, {pays[3], pays[2], pays[1], pays[0]}, 1'b1);
            #1;
            chk("rot_src",   32'(bus.out_src),   32'(k % 4));
            chk("rot_data",  32'(bus.out_data),  32'(pays[k % 4]));
            chk("rot_valid", 32'(bus.out_valid), 1);
        end

        // Backpressure: hold 5 from req0, then drain with refill from req1.
        step(4'b0001, 16'h0005, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(4'b0011, 16'h0025, 1'b0);
            #1;
            chk("bp_data", 32'(bus.out_data), 32'h5);
            chk("bp_src",  32'(bus.out_src),  0);
        end
        step(4'b0011, 16'h0025, 1'b1);
        #1;
        chk("bp_refill_src",  32'(bus.out_src),  1);
        chk("bp_refill_data", 32'(bus.out_data), 32'h2);

        // Lock: req2 sends hi=all-ones, keeps the channel over req3.
        step(4'b1100, {4'h3, 4'(lock_pl), 8'h00}, 1'b1);
        #1;
        chk("lock_set", 32'(bus.locked), 1);
        step(4'b1100, {4'h3, 4'h5, 8'h00}, 1'b1);
        #1;
        chk("lock_owner_src", 32'(bus.out_src), 2);
        chk("lock_clear",     32'(bus.locked),  0);
        step(4'b1000, {4'h3, 4'h5, 8'h00}, 1'b1);
        #1;
        chk("lock_next_src", 32'(bus.out_src), 3);

        // Wrap and sparse: ptr moved to 3, then req3/req0 only.
        step(4'b0100, 16'h0100, 1'b1);
        step(4'b1001, 16'h7009, 1'b1);
        #1;
        chk("wrap_src3", 32'(bus.out_src), 3);
        step(4'b1001, 16'h7009, 1'b1);
        #1;
        chk("wrap_src0", 32'(bus.out_src), 0);
        step(4'b0011, 16'h00A9, 1'b1);
        #1;
        chk("wrap_ptr1", 32'(bus.out_src), 1);

        // Idle: output drains, pointer stays at 2.
        for (int k = 0; k < 5; k++) step(4'b0000, 16'h0000, 1'b1);
        #1;
        chk("idle_valid", 32'(bus.out_valid), 0);
        step(4'b0110, 16'h0B60, 1'b1);
        #1;
        chk("idle_ptr_src", 32'(bus.out_src), 2);

        // Asynchronous reset while holding a locked beat.
        step(4'b0000, 16'h0000, 1'b1);
        step(4'b0100, {4'h0, 4'(lock_pl), 8'h00}, 1'b0);
        #1;
        chk("pre_rst_valid",  32'(bus.out_valid), 1);
        chk("pre_rst_locked", 32'(bus.locked),    1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid",     32'(bus.out_valid), 0);
        chk("arst_data",      32'(bus.out_data),  0);
        chk("arst_src",       32'(bus.out_src),   0);
        chk("arst_locked",    32'(bus.locked),    0);
        chk("arst_req_ready", 32'(bus.req_ready), 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        step(4'b0000, 16'h0000, 1'b1);
        step(4'b0000, 16'h0000, 1'b1);
        #1;
        chk("post_rst_valid", 32'(bus.out_valid), 0);

        // Randomized traffic, including random locks and backpressure.
        for (int k = 0; k < 400; k++) begin
            step(4'($urandom), 16'($urandom), ($urandom_range(0, 9) < 7));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
